// File: rtl/dp_i2f.sv
// dp_i2f: iterative 64-bit integer to IEEE-754 binary64 converter, round-to-nearest-even.
// Build option DP_I2F_UNSIGNED_EN adds the in_unsigned port and the unsigned operand path.
module dp_i2f #(
   parameter int SHIFT_STEP = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
`ifdef DP_I2F_UNSIGNED_EN
   input  logic        in_unsigned,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_result,
   output logic        out_inexact
);
   // state | meaning
   // IDLE  | waiting for an operand
   // NORM  | shifting mag left until bit 63 is set
   // ROUND | round-to-nearest-even and pack the result
   // DONE  | result held until out_ready
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] NORM  = 2'd1;
   localparam logic [1:0] ROUND = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   localparam logic [4:0] STEP  = 5'(SHIFT_STEP);

   logic [1:0]  state;
   logic [63:0] mag;
   logic [10:0] exp_q;
   logic        sign_q;

   logic        in_sign;
   logic [63:0] in_mag;
   logic [4:0]  shift_k;
   logic        found;
   logic [51:0] frac;
   logic        guard;
   logic        sticky;
   logic        round_up;
   logic [52:0] frac_inc;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_comb begin
`ifdef DP_I2F_UNSIGNED_EN
      in_sign = in_data[63] & ~in_unsigned;
`else
      in_sign = in_data[63];
`endif
      in_mag = in_sign ? (~in_data + 64'd1) : in_data;
   end

   // leading zeros within the top SHIFT_STEP bits, capped at SHIFT_STEP
   always_comb begin
      shift_k = STEP;
      found   = 1'b0;
      for (int i = 0; i < SHIFT_STEP; i++) begin
         if (!found && mag[63-i]) begin
            shift_k = 5'(i);
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      frac     = mag[62:11];
      guard    = mag[10];
      sticky   = |mag[9:0];
      round_up = guard & (sticky | frac[0]);
      frac_inc = {1'b0, frac} + {52'd0, round_up};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         mag         <= '0;
         exp_q       <= '0;
         sign_q      <= 1'b0;
         out_result  <= '0;
         out_inexact <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign_q <= in_sign;
                  mag    <= in_mag;
                  exp_q  <= 11'd1086;
                  if (in_data == 64'd0) begin
                     out_result  <= '0;
                     out_inexact <= 1'b0;
                     state       <= DONE;
                  end else begin
                     state <= NORM;
                  end
               end
            end
            NORM: begin
               if (mag[63]) begin
                  state <= ROUND;
               end else begin
                  mag   <= mag << shift_k;
                  exp_q <= exp_q - {6'd0, shift_k};
               end
            end
            ROUND: begin
               // a carry out of the fraction leaves frac_inc[51:0] at zero and bumps the exponent
               out_result  <= {sign_q, exp_q + {10'd0, frac_inc[52]}, frac_inc[51:0]};
               out_inexact <= guard | sticky;
               state       <= DONE;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
